// File: rtl/prienc_pkg.sv
// Shared definitions for the priority encode/decode family.
// Holds the code/data widths, the buffer occupancy state encodings and
// small helpers for mapping between an encoded index and a request vector.
package prienc_pkg;

  localparam int CODE_W = 2;
  localparam int DATA_W = 4;

  // Occupancy of the word buffer.
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } occ_state_t;

  // Index -> request vector. thermo=0 gives one-hot; thermo=1 sets every bit
  // from the index down to 0, which is the largest vector that still encodes
  // back to the same index. any=0 always yields an all-zero vector.
  function automatic logic [DATA_W-1:0] decode_word(input logic [CODE_W-1:0] code,
                                                    input logic              any,
                                                    input logic              thermo);
    logic [DATA_W-1:0] w;
    w = '0;
    if (any) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (thermo ? (i <= int'(code)) : (i == int'(code))) w[i] = 1'b1;
      end
    end
    return w;
  endfunction

  // Request vector -> {any, index}; the highest set bit wins.
  function automatic logic [CODE_W:0] encode_req(input logic [DATA_W-1:0] req);
    logic [CODE_W:0] r;
    r = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (req[i]) r = {1'b1, CODE_W'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/priority_dec_4bit_if.sv
// Handshake bundle for priority_dec_4bit.
//   in_valid/in_ready/in_code/in_any/mode : code input stream
//   out_valid/out_ready/out_d             : decoded word output stream
//   cnt_clr/word_cnt                      : delivered-word counter
// master = producer/consumer environment, slave = the decoder block.
interface priority_dec_4bit_if #(parameter int CNT_W = 8) ();
  import prienc_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_code;
  logic              in_any;
  logic              mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_d;
  logic              cnt_clr;
  logic [CNT_W-1:0]  word_cnt;

  modport master (
    output in_valid, in_code, in_any, mode, out_ready, cnt_clr,
    input  in_ready, out_valid, out_d, word_cnt
  );

  modport slave (
    input  in_valid, in_code, in_any, mode, out_ready, cnt_clr,
    output in_ready, out_valid, out_d, word_cnt
  );

endinterface

// File: rtl/prienc_fifo.sv
// Small word buffer with a registered head output.
//   clk, rst            : clock, async active-high reset
//   wr_valid/wr_ready   : push side; wr_ready = not full
//   wr_data             : word to store
//   rd_valid/rd_ready   : pop side; rd_valid and rd_data are flops
//   rd_data             : head word, zero while empty
//
// state      | meaning
// -----------+--------------------------------------------
// ST_EMPTY   | no words held, rd_valid=0
// ST_PARTIAL | 1..DEPTH-1 words held
// ST_FULL    | DEPTH words held, pushes are refused
module prienc_fifo import prienc_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  occ_state_t state_q, state_d;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             push, pop;
  logic [WIDTH-1:0] head_d;
  logic             rd_valid_q;
  logic [WIDTH-1:0] rd_data_q;

  assign push = wr_valid && wr_ready;
  assign pop  = rd_valid_q && rd_ready;

  // Pointers are PTR_W bits wide and DEPTH is a power of two, so the
  // increment wraps modulo DEPTH on its own.
  assign rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Next head word. When the slot about to become the head is the one being
  // written on this same edge (buffer empty, or down to its last word while
  // that word is popped), forward the incoming word instead of the stale slot.
  assign head_d = (push && (wr_ptr_q == rd_ptr_d)) ? wr_data : mem[rd_ptr_d];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) state_d = (DEPTH == 1) ? ST_FULL : ST_PARTIAL;
      end
      ST_PARTIAL: begin
        if (push && !pop && (occ_q == OCC_W'(DEPTH - 1))) state_d = ST_FULL;
        else if (pop && !push && (occ_q == OCC_W'(1)))    state_d = ST_EMPTY;
      end
      ST_FULL: begin
        if (pop) state_d = (DEPTH == 1) ? ST_EMPTY : ST_PARTIAL;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Output logic
  always_comb begin
    wr_ready = (state_q != ST_FULL);
    rd_valid = rd_valid_q;
    rd_data  = rd_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      rd_valid_q <= (state_d != ST_EMPTY);
      rd_data_q  <= (state_d != ST_EMPTY) ? head_d : '0;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/priority_dec_4bit.sv
// Priority index decoder with buffered output stream.
//   clk, rst  : clock, async active-high reset
//   bus       : slave side of priority_dec_4bit_if
//               in_*      accepted codes are decoded immediately (one-hot or
//                         thermometer per mode) and the 4-bit word is buffered
//               out_*     registered decoded words, held under back-pressure
//               word_cnt  saturating count of delivered words, cnt_clr wins
module priority_dec_4bit import prienc_pkg::*; #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  priority_dec_4bit_if.slave   bus
);

  logic [DATA_W-1:0] dec_word;
  logic              out_hs;
  logic [CNT_W-1:0]  word_cnt_q;

  // Decode at accept time so the buffer holds words, not codes; mode is
  // therefore latched per entry.
  assign dec_word = decode_word(bus.in_code, bus.in_any, bus.mode);

  prienc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (bus.in_valid),
    .wr_ready (bus.in_ready),
    .wr_data  (dec_word),
    .rd_valid (bus.out_valid),
    .rd_ready (bus.out_ready),
    .rd_data  (bus.out_d)
  );

  assign out_hs = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          word_cnt_q <= '0;
    else if (bus.cnt_clr)             word_cnt_q <= '0;
    else if (out_hs && !(&word_cnt_q)) word_cnt_q <= word_cnt_q + CNT_W'(1);
  end

  assign bus.word_cnt = word_cnt_q;

endmodule

// File: tb/tb_priority_dec_4bit.sv
module tb_priority_dec_4bit;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_chk;

  priority_dec_4bit_if #(.CNT_W(8)) bus ();
  priority_dec_4bit_if #(.CNT_W(2)) bus_s ();

  priority_dec_4bit #(.FIFO_DEPTH(2), .CNT_W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  priority_dec_4bit #(.FIFO_DEPTH(2), .CNT_W(2)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 0; bus.in_code = 0; bus.in_any = 0; bus.mode = 0;
    bus.out_ready = 0; bus.cnt_clr = 0;
    bus_s.in_valid = 0; bus_s.in_code = 0; bus_s.in_any = 0; bus_s.mode = 0;
    bus_s.out_ready = 0; bus_s.cnt_clr = 0;
    step(); step();
    n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); else n_pass++;
    n_chk++; if (bus.out_d !== 4'b0000) $display("FAIL reset_out_d got %b exp 0000", bus.out_d); else n_pass++;
    n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); else n_pass++;
    n_chk++; if (bus.word_cnt !== 8'd0) $display("FAIL reset_word_cnt got %0d exp 0", bus.word_cnt); else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    bus.out_ready = 1; bus.in_valid = 1; bus.in_code = 2; bus.in_any = 1; bus.mode = 0;
    step();
    bus.in_valid = 0;
    n_chk++; if (bus.out_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", bus.out_valid); else n_pass++;
    n_chk++; if (bus.out_d !== 4'b0100) $display("FAIL single_out_d got %b exp 0100", bus.out_d); else n_pass++;
    step();
    n_chk++; if (bus.word_cnt !== 8'd1) $display("FAIL single_word_cnt got %0d exp 1", bus.word_cnt); else n_pass++;
    n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL single_drain got %b exp 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_thermo();
    logic [1:0] codes [5];
    logic       anys  [5];
    logic [3:0] exp   [5];
    codes = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    anys  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp   = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000};
    bus.out_ready = 1; bus.mode = 1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1; bus.in_code = codes[i]; bus.in_any = anys[i];
      step();
      n_chk++;
      if (bus.out_valid !== 1'b1 || bus.out_d !== exp[i])
        $display("FAIL thermo_%0d got v=%b d=%b exp v=1 d=%b", i, bus.out_valid, bus.out_d, exp[i]);
      else n_pass++;
    end
    bus.in_valid = 0;
    step();
    n_chk++; if (bus.word_cnt !== 8'd6) $display("FAIL thermo_word_cnt got %0d exp 6", bus.word_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] codes [4];
    logic [3:0] exp   [4];
    codes = '{2'd3, 2'd1, 2'd0, 2'd2};
    exp   = '{4'b1000, 4'b0010, 4'b0001, 4'b0100};
    bus.out_ready = 1; bus.mode = 0; bus.in_any = 1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1; bus.in_code = codes[i];
      step();
      n_chk++;
      if (bus.out_valid !== 1'b1 || bus.out_d !== exp[i] || bus.in_ready !== 1'b1)
        $display("FAIL b2b_%0d got v=%b d=%b rdy=%b exp v=1 d=%b rdy=1",
                 i, bus.out_valid, bus.out_d, bus.in_ready, exp[i]);
      else n_pass++;
    end
    bus.in_valid = 0;
    step();
    n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_drain got %b exp 0", bus.out_valid); else n_pass++;
    n_chk++; if (bus.word_cnt !== 8'd10) $display("FAIL b2b_word_cnt got %0d exp 10", bus.word_cnt); else n_pass++;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 0; bus.mode = 0; bus.in_any = 1;
    bus.in_valid = 1; bus.in_code = 0;
    step();
    n_chk++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_d !== 4'b0001)
      $display("FAIL bp_first got rdy=%b v=%b d=%b exp rdy=1 v=1 d=0001", bus.in_ready, bus.out_valid, bus.out_d);
    else n_pass++;
    bus.in_code = 1;
    step();
    n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL bp_full got rdy=%b exp 0", bus.in_ready); else n_pass++;
    bus.in_code = 3;
    step();
    n_chk++;
    if (bus.in_ready !== 1'b0 || bus.out_d !== 4'b0001)
      $display("FAIL bp_hold got rdy=%b d=%b exp rdy=0 d=0001", bus.in_ready, bus.out_d);
    else n_pass++;
    bus.out_ready = 1;
    step();
    n_chk++;
    if (bus.out_d !== 4'b0010 || bus.in_ready !== 1'b1)
      $display("FAIL bp_second got d=%b rdy=%b exp d=0010 rdy=1", bus.out_d, bus.in_ready);
    else n_pass++;
    step();
    bus.in_valid = 0;
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_d !== 4'b1000)
      $display("FAIL bp_third got v=%b d=%b exp v=1 d=1000", bus.out_valid, bus.out_d);
    else n_pass++;
    step();
    n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL bp_drain got %b exp 0", bus.out_valid); else n_pass++;
    n_chk++; if (bus.word_cnt !== 8'd13) $display("FAIL bp_word_cnt got %0d exp 13", bus.word_cnt); else n_pass++;
  endtask

  task automatic test_saturate();
    int exp_cnt;
    bus_s.out_ready = 1; bus_s.in_any = 1; bus_s.mode = 0; bus_s.in_code = 1;
    for (int i = 0; i < 5; i++) begin
      bus_s.in_valid = 1;
      step();
      bus_s.in_valid = 0;
      step();
      exp_cnt = (i + 1 > 3) ? 3 : i + 1;
      n_chk++;
      if (bus_s.word_cnt !== 2'(exp_cnt))
        $display("FAIL sat_cnt_%0d got %0d exp %0d", i, bus_s.word_cnt, exp_cnt);
      else n_pass++;
    end
    bus_s.in_valid = 1;
    step();
    bus_s.in_valid = 0; bus_s.cnt_clr = 1;
    step();
    bus_s.cnt_clr = 0;
    n_chk++; if (bus_s.word_cnt !== 2'd0) $display("FAIL sat_clr got %0d exp 0", bus_s.word_cnt); else n_pass++;
    n_chk++; if (bus_s.out_valid !== 1'b0) $display("FAIL sat_clr_pop got v=%b exp 0", bus_s.out_valid); else n_pass++;
    bus_s.in_valid = 1;
    step();
    bus_s.in_valid = 0;
    step();
    n_chk++; if (bus_s.word_cnt !== 2'd1) $display("FAIL sat_recount got %0d exp 1", bus_s.word_cnt); else n_pass++;
  endtask

  task automatic test_reset_full();
    bus.out_ready = 0; bus.mode = 0; bus.in_any = 1; bus.in_valid = 1;
    bus.in_code = 2;
    step();
    bus.in_code = 3;
    step();
    bus.in_valid = 0;
    n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL rf_full got rdy=%b exp 0", bus.in_ready); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.out_d !== 4'b0000 || bus.in_ready !== 1'b1 || bus.word_cnt !== 8'd0)
      $display("FAIL rf_async got v=%b d=%b rdy=%b cnt=%0d exp v=0 d=0000 rdy=1 cnt=0",
               bus.out_valid, bus.out_d, bus.in_ready, bus.word_cnt);
    else n_pass++;
    step();
    rst = 1'b0;
    bus.out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if (bus.out_valid !== 1'b0 || bus.out_d !== 4'b0000)
        $display("FAIL rf_stale_%0d got v=%b d=%b exp v=0 d=0000", i, bus.out_valid, bus.out_d);
      else n_pass++;
    end
    bus.in_valid = 1; bus.in_code = 1; bus.mode = 1;
    step();
    bus.in_valid = 0;
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_d !== 4'b0011)
      $display("FAIL rf_new got v=%b d=%b exp v=1 d=0011", bus.out_valid, bus.out_d);
    else n_pass++;
    step();
    n_chk++; if (bus.word_cnt !== 8'd1) $display("FAIL rf_word_cnt got %0d exp 1", bus.word_cnt); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_chk  = 0;
    test_reset();
    test_single();
    test_thermo();
    test_back_to_back();
    test_backpressure();
    test_saturate();
    test_reset_full();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
